score_timer: RTL

- Producer side of the score/time display interface: generates the `time_show` countdown and the accumulated `score` that the 7-segment score display consumes.
- Owns the game-round state machine (idle, running, over), the one-second prescaler, and saturating score accumulation from gold-capture events.
- Sits between hook/gold collision logic and the score display block; all outputs are registered and run in the system clock domain.

---
 rtl/score_timer.sv | 109 ++++++++++
 1 files changed

// File: rtl/score_timer.sv
// Game-round controller: one-second prescaler, countdown of the seconds left,
// and saturating score accumulation from gold captures. All outputs registered.
module score_timer #(
  parameter int TICK_DIV     = 100000000,
  parameter int GAME_SECONDS = 60,
  parameter int SCORE_MAX    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gold_add,
  input  logic [7:0] gold_value,
  output logic [7:0] time_show,
  output logic [7:0] score,
  output logic       running,
  output logic       game_over,
  output logic       sec_tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] TIME_LOAD  = 8'(GAME_SECONDS);
  localparam logic [8:0] SCORE_CEIL = 9'(SCORE_MAX);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    time_q, time_d;
  logic [7:0]    score_q, score_d;
  logic          running_q, running_d;
  logic          game_over_q, game_over_d;
  logic          sec_tick_q, sec_tick_d;
  logic [8:0]    score_sum;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    time_d     = time_q;
    score_d    = score_q;
    sec_tick_d = 1'b0;
    score_sum  = {1'b0, score_q} + {1'b0, gold_value};

    case (state_q)
      RUN: begin
        if (gold_add) begin
          score_d = (score_sum > SCORE_CEIL) ? SCORE_CEIL[7:0] : score_sum[7:0];
        end
        // The final tick both zeroes the countdown and ends the round on one edge.
        if (presc_q == PRESC_LAST) begin
          presc_d    = '0;
          sec_tick_d = 1'b1;
          if (time_q <= 8'd1) begin
            time_d  = 8'd0;
            state_d = OVER;
          end else begin
            time_d = time_q - 8'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      IDLE, OVER: begin
        presc_d = '0;
        if (state_q == OVER) begin
          time_d = 8'd0;
        end
        if (start) begin
          time_d  = TIME_LOAD;
          score_d = 8'd0;
          state_d = (GAME_SECONDS == 0) ? OVER : RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    running_d   = (state_d == RUN);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      time_q      <= TIME_LOAD;
      score_q     <= 8'd0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
      sec_tick_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      time_q      <= time_d;
      score_q     <= score_d;
      running_q   <= running_d;
      game_over_q <= game_over_d;
      sec_tick_q  <= sec_tick_d;
    end
  end

  assign time_show = time_q;
  assign score     = score_q;
  assign running   = running_q;
  assign game_over = game_over_q;
  assign sec_tick  = sec_tick_q;

endmodule
